// File: rtl/aug_batch_loader_if.sv
// aug_batch_loader_if: bundles the buffer-BRAM read port, augmentation-BRAM write port,
// kernel output and the per-buffer ready/release handshake of the batch loader.
interface aug_batch_loader_if #(
  parameter int ADDR_WIDTH_PS  = 32,
  parameter int DATA_WIDTH_PS  = 32,
  parameter int ADDR_WIDTH_INT = 11,
  parameter int PIXEL_WIDTH    = 8,
  parameter int KERNEL_SIZE    = 9,
  parameter int KERNEL_WIDTH   = 12,
  parameter int NUM_CHANNELS   = 2
);
  logic                                 read_kernel;
  logic                                 start;
  logic [ADDR_WIDTH_PS-1:0]             bram_buffer_addr;
  logic [DATA_WIDTH_PS-1:0]             bram_buffer_data;
  logic [ADDR_WIDTH_INT-1:0]            aug_bram_addr;
  logic [PIXEL_WIDTH-1:0]               aug_bram_data;
  logic [NUM_CHANNELS-1:0]              aug_bram_w_enable;
  logic [KERNEL_SIZE*KERNEL_WIDTH-1:0]  kernel_out;
  logic                                 kernel_valid;
  logic [1:0]                           buf_ready;
  logic [1:0]                           buf_release;
  logic                                 busy;
  logic                                 done;
  logic [15:0]                          images_loaded;
  logic [31:0]                          stall_cycles;

  modport master (
    input  read_kernel, start, bram_buffer_data, buf_release,
    output bram_buffer_addr, aug_bram_addr, aug_bram_data, aug_bram_w_enable,
           kernel_out, kernel_valid, buf_ready, busy, done, images_loaded, stall_cycles
  );

  modport slave (
    output read_kernel, start, bram_buffer_data, buf_release,
    input  bram_buffer_addr, aug_bram_addr, aug_bram_data, aug_bram_w_enable,
           kernel_out, kernel_valid, buf_ready, busy, done, images_loaded, stall_cycles
  );
endinterface

// File: rtl/aug_batch_loader.sv
// aug_batch_loader: loads the conv kernel and unpacks image batches into ping-pong aug BRAM regions.
// Define AUG_LOADER_STALL_CNT_EN to enable the WAIT_BUF stall cycle counter on stall_cycles.
module aug_batch_loader #(
  parameter int                        ADDR_WIDTH_PS    = 32,
  parameter int                        DATA_WIDTH_PS    = 32,
  parameter int                        ADDR_WIDTH_INT   = 11,
  parameter int                        PIXEL_WIDTH      = 8,
  parameter int                        NUM_IMAGES       = 16,
  parameter int                        NUM_PIXELS       = 784,
  parameter int                        KERNEL_SIZE      = 9,
  parameter int                        KERNEL_WIDTH     = 12,
  parameter int                        NUM_CHANNELS     = 2,
  parameter int                        READ_LATENCY     = 1,
  parameter logic [ADDR_WIDTH_PS-1:0]  KERNEL_BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH_PS-1:0]  IMAGE_BASE_ADDR  = 32'h0000_0024,
  parameter logic [ADDR_WIDTH_INT-1:0] BRAM_INT_BASE1   = 11'h000,
  parameter logic [ADDR_WIDTH_INT-1:0] BRAM_INT_BASE2   = 11'h310
) (
  input logic               clk,
  input logic               reset,
  aug_batch_loader_if.master bus
);
  localparam int PPW    = DATA_WIDTH_PS / PIXEL_WIDTH;
  localparam int PIX_W  = $clog2(NUM_PIXELS + 1);
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WAIT_W = $clog2(READ_LATENCY + 1);
  localparam int KCNT_W = $clog2(KERNEL_SIZE + READ_LATENCY + 1);
  localparam logic [ADDR_WIDTH_PS-1:0] ADDR_STEP = ADDR_WIDTH_PS'(DATA_WIDTH_PS / 8);

  typedef enum logic [2:0] {IDLE, KREAD, WAIT_BUF, FETCH, UNPACK, FINISH} state_t;

  state_t                              r_state;
  logic [ADDR_WIDTH_PS-1:0]            r_addr;
  logic [KCNT_W-1:0]                   r_kcnt;
  logic [KERNEL_SIZE*KERNEL_WIDTH-1:0] r_kernel;
  logic                                r_kernel_valid;
  logic [WAIT_W-1:0]                   r_wait;
  logic [DATA_WIDTH_PS-1:0]            r_word;
  logic [SLOT_W-1:0]                   r_slot;
  logic [PIX_W-1:0]                    r_pix;
  logic [ADDR_WIDTH_INT-1:0]           r_aug_addr;
  logic [PIXEL_WIDTH-1:0]              r_aug_data;
  logic                                r_aug_we;
  logic [15:0]                         r_images_loaded;
  logic                                r_done;
  logic [1:0]                          r_buf_ready;

  logic                      w_buf;
  logic [ADDR_WIDTH_INT-1:0] w_base;
  logic                      w_start_batch;
  logic                      w_image_done;
  logic [1:0]                w_set_ready;
  logic [KCNT_W-1:0]         w_kslot;

  // The image index equals the number of images already completed, so its LSB picks ping or pong.
  assign w_buf         = r_images_loaded[0];
  assign w_base        = w_buf ? BRAM_INT_BASE2 : BRAM_INT_BASE1;
  assign w_start_batch = (r_state == IDLE) && !bus.read_kernel && bus.start;
  assign w_image_done  = (r_state == UNPACK) && (r_slot == SLOT_W'(PPW - 1)) &&
                         (r_pix == PIX_W'(NUM_PIXELS));
  assign w_set_ready   = w_image_done ? (2'b01 << w_buf) : 2'b00;
  assign w_kslot       = r_kcnt - KCNT_W'(READ_LATENCY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_kcnt          <= '0;
      r_kernel        <= '0;
      r_kernel_valid  <= 1'b0;
      r_wait          <= '0;
      r_word          <= '0;
      r_slot          <= '0;
      r_pix           <= '0;
      r_aug_addr      <= '0;
      r_aug_data      <= '0;
      r_aug_we        <= 1'b0;
      r_images_loaded <= '0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.read_kernel) begin
            r_kernel_valid <= 1'b0;
            r_kcnt         <= '0;
            r_addr         <= KERNEL_BASE_ADDR;
            r_state        <= KREAD;
          end else if (bus.start) begin
            r_done          <= 1'b0;
            r_images_loaded <= '0;
            r_addr          <= IMAGE_BASE_ADDR;
            r_pix           <= '0;
            r_state         <= WAIT_BUF;
          end
        end
        // Addresses stream out one per cycle; slot i is captured READ_LATENCY cycles behind its address.
        KREAD: begin
          r_kcnt <= r_kcnt + 1'b1;
          if (r_kcnt < KCNT_W'(KERNEL_SIZE - 1))
            r_addr <= r_addr + ADDR_STEP;
          if (r_kcnt >= KCNT_W'(READ_LATENCY)) begin
            r_kernel[w_kslot*KERNEL_WIDTH +: KERNEL_WIDTH] <= bus.bram_buffer_data[KERNEL_WIDTH-1:0];
            if (w_kslot == KCNT_W'(KERNEL_SIZE - 1)) begin
              r_kernel_valid <= 1'b1;
              r_state        <= IDLE;
            end
          end
        end
        WAIT_BUF: begin
          if (!r_buf_ready[w_buf]) begin
            r_wait  <= '0;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (r_wait == WAIT_W'(READ_LATENCY)) begin
            r_word     <= bus.bram_buffer_data >> PIXEL_WIDTH;
            r_aug_data <= bus.bram_buffer_data[PIXEL_WIDTH-1:0];
            r_aug_addr <= w_base + ADDR_WIDTH_INT'(r_pix);
            r_aug_we   <= 1'b1;
            r_pix      <= r_pix + 1'b1;
            r_slot     <= '0;
            r_state    <= UNPACK;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        // Images are contiguous in the buffer, so the word address simply keeps counting across images.
        UNPACK: begin
          if (r_slot == SLOT_W'(PPW - 1)) begin
            r_aug_we <= 1'b0;
            r_addr   <= r_addr + ADDR_STEP;
            if (r_pix == PIX_W'(NUM_PIXELS)) begin
              r_images_loaded <= r_images_loaded + 1'b1;
              r_state         <= FINISH;
            end else begin
              r_wait  <= '0;
              r_state <= FETCH;
            end
          end else begin
            r_aug_data <= r_word[PIXEL_WIDTH-1:0];
            r_word     <= r_word >> PIXEL_WIDTH;
            r_aug_addr <= w_base + ADDR_WIDTH_INT'(r_pix);
            r_pix      <= r_pix + 1'b1;
            r_slot     <= r_slot + 1'b1;
          end
        end
        FINISH: begin
          if (r_images_loaded == 16'(NUM_IMAGES)) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_pix   <= '0;
            r_state <= WAIT_BUF;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A release beats a same-cycle set; start wipes both buffers for the new batch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_buf_ready <= '0;
    else if (w_start_batch)
      r_buf_ready <= '0;
    else
      r_buf_ready <= (r_buf_ready | w_set_ready) & ~bus.buf_release;
  end

`ifdef AUG_LOADER_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cycles <= '0;
    else if (w_start_batch)
      r_stall_cycles <= '0;
    else if ((r_state == WAIT_BUF) && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.bram_buffer_addr  = r_addr;
  assign bus.aug_bram_addr     = r_aug_addr;
  assign bus.aug_bram_data     = r_aug_data;
  assign bus.aug_bram_w_enable = {NUM_CHANNELS{r_aug_we}};
  assign bus.kernel_out        = r_kernel;
  assign bus.kernel_valid      = r_kernel_valid;
  assign bus.buf_ready         = r_buf_ready;
  assign bus.busy              = (r_state != IDLE);
  assign bus.done              = r_done;
  assign bus.images_loaded     = r_images_loaded;
endmodule

// File: tb/tb_aug_batch_loader.sv
// tb_aug_batch_loader: randomized kernel and batch loads checked against a byte-level model
// of the buffer contents and the ping-pong placement rules.
`timescale 1ns/1ps
module tb_aug_batch_loader;
  localparam int NumImages     = 4;
  localparam int NumPixels     = 784;
  localparam int ImageBase     = 32'h24;
  localparam int Ppw           = 4;
  localparam int ReadLatency   = 1;
  localparam int KernelSize    = 9;
  localparam int Wpi           = NumPixels / Ppw;
  localparam int CyclesPerWord = 1 + ReadLatency + Ppw;
  localparam logic [10:0] Base1 = 11'h000;
  localparam logic [10:0] Base2 = 11'h310;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  aug_batch_loader_if busIf ();

  aug_batch_loader #(.NUM_IMAGES(NumImages)) dut (
    .clk  (clk),
    .reset(rstN),
    .bus  (busIf.master)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Buffer BRAM: word-addressed storage with a one-cycle registered read port.
  logic [31:0] bufMem [0:1023];
  always @(posedge clk) busIf.bram_buffer_data <= bufMem[busIf.bram_buffer_addr[11:2]];

  // Every augmentation write is logged once, sampled mid-cycle.
  logic [18:0] writeLog [$];
  int weBad = 0;
  always @(negedge clk) begin
    if (busIf.aug_bram_w_enable != 2'b00) begin
      writeLog.push_back({busIf.aug_bram_addr, busIf.aug_bram_data});
      if (busIf.aug_bram_w_enable != 2'b11) weBad++;
    end
  end

  // Downstream consumer: releases each ready buffer releaseDelay cycles after seeing it,
  // unless held; forceSeq bumps inject a one-off release pulse on forceMask.
  logic [1:0] holdMask = 2'b00;
  logic [1:0] forceMask = 2'b00;
  int releaseDelay = 0;
  int forceSeq = 0;
  int seenSeq = 0;
  int relCnt [2] = '{0, 0};
  always @(negedge clk) begin
    logic [1:0] rel;
    rel = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (busIf.buf_ready[b] && !holdMask[b]) begin
        if (relCnt[b] >= releaseDelay) rel[b] = 1'b1;
        relCnt[b]++;
      end else begin
        relCnt[b] = 0;
      end
    end
    if (forceSeq != seenSeq) begin
      rel     = rel | forceMask;
      seenSeq = forceSeq;
    end
    busIf.buf_release = rel;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rk, input logic st);
    @(negedge clk);
    busIf.read_kernel = rk;
    busIf.start       = st;
    @(posedge clk);
    #1;
    busIf.read_kernel = 1'b0;
    busIf.start       = 1'b0;
  endtask

  task automatic waitKernelValid(output int latency, output int busyLow);
    latency = 0;
    busyLow = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (busIf.kernel_valid) begin
        latency = c;
        break;
      end
      if (!busIf.busy) busyLow++;
    end
  endtask

  task automatic waitDone(input string tag, input int limit);
    for (int c = 0; c < limit; c++) begin
      @(posedge clk);
      #1;
      if (busIf.done) break;
    end
    checkOutput({tag, " done"}, busIf.done, 1);
  endtask

  task automatic waitWrites(input string tag, input int logStart, input int count, input int limit);
    for (int c = 0; c < limit; c++) begin
      @(posedge clk);
      #1;
      if (writeLog.size() - logStart >= count) break;
    end
    checkOutput({tag, " writes reached"}, (writeLog.size() - logStart >= count), 1);
  endtask

  // Pixel p of image n is byte (base + n*bytes-per-image + p) of the little-endian buffer.
  function automatic logic [7:0] pixelOf(input int n, input int p);
    int          byteAddr;
    logic [31:0] w;
    byteAddr = ImageBase + n * NumPixels + p;
    w = bufMem[byteAddr / 4];
    return w[8 * (byteAddr % 4) +: 8];
  endfunction

  task automatic checkBatch(input string tag, input int logStart);
    int bad = 0;
    int n;
    int p;
    logic [10:0] expAddr;
    checkOutput({tag, " write count"}, writeLog.size() - logStart, NumImages * NumPixels);
    for (int i = 0; i < NumImages * NumPixels && logStart + i < writeLog.size(); i++) begin
      n = i / NumPixels;
      p = i % NumPixels;
      expAddr = (((n % 2) != 0) ? Base2 : Base1) + 11'(p);
      if (writeLog[logStart + i] != {expAddr, pixelOf(n, p)}) bad++;
    end
    checkOutput({tag, " pixel stream"}, bad, 0);
    checkOutput({tag, " images_loaded"}, busIf.images_loaded, NumImages);
  endtask

  task automatic randomizeImages();
    for (int i = 9; i < 1024; i++) bufMem[i] = $urandom;
  endtask

  initial begin
    int lat;
    int busyLow;
    int logStart;
    int riseCycle;
    logic [63:0] obs;

    busIf.read_kernel = 1'b0;
    busIf.start       = 1'b0;
    for (int i = 0; i < 1024; i++) bufMem[i] = $urandom;
    for (int i = 0; i < KernelSize; i++) bufMem[i] = 32'hFFFF_F000 + i;
    bufMem[9] = 32'h4433_2211;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busIf.busy, 0);
    checkOutput("reset done", busIf.done, 0);
    checkOutput("reset kernel_valid", busIf.kernel_valid, 0);
    checkOutput("reset kernel_out zero", (busIf.kernel_out == '0), 1);
    checkOutput("reset buf_ready", busIf.buf_ready, 0);
    checkOutput("reset images_loaded", busIf.images_loaded, 0);
    checkOutput("reset w_enable", busIf.aug_bram_w_enable, 0);
    checkOutput("reset buffer addr", busIf.bram_buffer_addr, 0);
    checkOutput("reset stall_cycles", busIf.stall_cycles, 0);
    @(negedge clk);
    rstN = 1'b1;

    // Fixed kernel pattern: weight i is the low 12 bits of 0xFFFFF000+i.
    applyStimulus(1'b1, 1'b0);
    waitKernelValid(lat, busyLow);
    checkOutput("kernel latency", lat, KernelSize + ReadLatency);
    checkOutput("kernel busy low during load", busyLow, 0);
    for (int i = 0; i < KernelSize; i++)
      checkOutput($sformatf("kernel weight %0d", i), busIf.kernel_out[i*12 +: 12], 12'(i));
    @(posedge clk);
    #1;
    checkOutput("kernel returns idle", busIf.busy, 0);

    // read_kernel and start together: only the kernel load happens.
    for (int i = 0; i < KernelSize; i++) bufMem[i] = $urandom;
    logStart = writeLog.size();
    applyStimulus(1'b1, 1'b1);
    waitKernelValid(lat, busyLow);
    checkOutput("collision kernel latency", lat, KernelSize + ReadLatency);
    for (int i = 0; i < KernelSize; i++)
      checkOutput($sformatf("random kernel weight %0d", i), busIf.kernel_out[i*12 +: 12], bufMem[i][11:0]);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("collision no batch busy", busIf.busy, 0);
    checkOutput("collision no writes", writeLog.size() - logStart, 0);

    // Batch A: immediate release, fixed first word.
    releaseDelay = 0;
    logStart = writeLog.size();
    applyStimulus(1'b0, 1'b1);
    riseCycle = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (busIf.buf_ready[0]) begin
        riseCycle = c;
        break;
      end
    end
    checkOutput("buf_ready0 rise cycle", riseCycle, 1 + Wpi * CyclesPerWord);
    for (int k = 0; k < 4; k++) begin
      obs = (writeLog.size() > logStart + k) ? 64'(writeLog[logStart + k]) : '1;
      checkOutput($sformatf("first word pixel %0d", k), obs, {11'(k), 8'(8'h11 * (k + 1))});
    end
    waitDone("batchA", 10000);
    checkBatch("batchA", logStart);
    checkOutput("w_enable uniform", weBad, 0);

    // Batch B: delayed release, fresh random images, start/read_kernel pulse while busy.
    randomizeImages();
    releaseDelay = 10;
    logStart = writeLog.size();
    applyStimulus(1'b0, 1'b1);
    checkOutput("start clears done", busIf.done, 0);
    repeat (500) @(posedge clk);
    applyStimulus(1'b1, 1'b1);
    checkOutput("busy ignores read_kernel", busIf.kernel_valid, 1);
    checkOutput("busy still loading", busIf.busy, 1);
    waitDone("batchB", 10000);
    checkBatch("batchB", logStart);

    // Backpressure: buffer 0 is never released until the hold is lifted.
    randomizeImages();
    releaseDelay = 0;
    holdMask = 2'b01;
    logStart = writeLog.size();
    applyStimulus(1'b0, 1'b1);
    waitWrites("backpressure", logStart, 2 * NumPixels, 4000);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("stalled busy", busIf.busy, 1);
    checkOutput("stalled buf_ready", busIf.buf_ready, 2'b01);
    checkOutput("stalled images_loaded", busIf.images_loaded, 2);
    checkOutput("stalled write count", writeLog.size() - logStart, 2 * NumPixels);
    forceMask = 2'b10;
    forceSeq++;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("release on zero bit", busIf.buf_ready, 2'b01);
    checkOutput("release on zero bit still stalled", writeLog.size() - logStart, 2 * NumPixels);
`ifdef AUG_LOADER_STALL_CNT_EN
    checkOutput("stall_cycles counted", (busIf.stall_cycles >= 100), 1);
`else
    checkOutput("stall_cycles tied off", busIf.stall_cycles, 0);
`endif
    holdMask = 2'b00;
    waitDone("backpressure", 10000);
    checkBatch("backpressure", logStart);

    // Reset in the middle of image 0, then a clean reload from image 0.
    randomizeImages();
    logStart = writeLog.size();
    applyStimulus(1'b0, 1'b1);
    waitWrites("midreset", logStart, 300, 4000);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midreset busy", busIf.busy, 0);
    checkOutput("midreset w_enable", busIf.aug_bram_w_enable, 0);
    checkOutput("midreset buffer addr", busIf.bram_buffer_addr, 0);
    checkOutput("midreset aug addr", busIf.aug_bram_addr, 0);
    checkOutput("midreset buf_ready", busIf.buf_ready, 0);
    checkOutput("midreset images_loaded", busIf.images_loaded, 0);
    checkOutput("midreset kernel_valid", busIf.kernel_valid, 0);
    @(negedge clk);
    rstN = 1'b1;
    logStart = writeLog.size();
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart fetch addr", busIf.bram_buffer_addr, ImageBase);
    waitDone("restart", 10000);
    checkBatch("restart", logStart);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/aug_batch_loader.md
Name: aug_batch_loader

Overview:
- Parametrised loader placed between the PS input buffer BRAM (DATA_WIDTH_PS-bit words) and the augmentation BRAMs (PIXEL_WIDTH-bit).
- On request, reads the convolution kernel from the buffer and presents it on a flat output bus.
- On start, unpacks a batch of NUM_IMAGES images into two ping-pong image regions.
- Each pixel is written to all NUM_CHANNELS augmentation BRAMs (blur, rotation, ...), with a per-buffer ready/release handshake to downstream consumers.

Parameters:
- ADDR_WIDTH_PS, 32, buffer BRAM byte-address width.
- DATA_WIDTH_PS, 32, buffer word width; must be a multiple of PIXEL_WIDTH.
- ADDR_WIDTH_INT, 11, augmentation BRAM address width.
- PIXEL_WIDTH, 8, bits per pixel.
- NUM_IMAGES, 16, images per batch (1..65535).
- NUM_PIXELS, 784, pixels per image; must be a multiple of PPW.
- KERNEL_SIZE, 9, kernel weights.
- KERNEL_WIDTH, 12, bits per weight; must be at most DATA_WIDTH_PS.
- NUM_CHANNELS, 2, augmentation BRAMs fed in parallel.
- READ_LATENCY, 1, buffer BRAM read latency in cycles (1..3).
- KERNEL_BASE_ADDR, 32'h0000_0000, byte address of kernel word 0.
- IMAGE_BASE_ADDR, 32'h0000_0024, byte address of image 0.
- BRAM_INT_BASE1, 11'h000, base address of ping buffer (buffer 0).
- BRAM_INT_BASE2, 11'h310, base address of pong buffer (buffer 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- read_kernel  in  1  level; sampled in IDLE.
- start  in  1  level; sampled in IDLE.
- bram_buffer_addr  out  ADDR_WIDTH_PS  byte address, word-aligned.
- bram_buffer_data  in  DATA_WIDTH_PS  read data, valid READ_LATENCY cycles after address.
- aug_bram_addr  out  ADDR_WIDTH_INT  shared write address.
- aug_bram_data  out  PIXEL_WIDTH  shared write data.
- aug_bram_w_enable  out  NUM_CHANNELS  per-channel write enable; all bits driven identically.
- kernel_out  out  KERNEL_SIZE*KERNEL_WIDTH  weight i at bits [i*KERNEL_WIDTH +: KERNEL_WIDTH].
- kernel_valid  out  1  kernel_out is stable.
- buf_ready  out  2  bit b set means buffer b holds a complete image.
- buf_release  in  2  one-cycle pulse per bit; consumer has finished buffer b.
- busy  out  1  high in any state other than IDLE.
- done  out  1  high after a batch completes.
- images_loaded  out  16  images completed in the current batch.
- stall_cycles  out  32  see Optional Feature.

Behaviour:
- Derived values: PPW = DATA_WIDTH_PS/PIXEL_WIDTH; WPI = NUM_PIXELS/PPW.
- Reset (reset=0, asynchronous) drives every output to 0 and puts the FSM in IDLE.
- States: IDLE, KREAD, WAIT_BUF, FETCH, UNPACK, FINISH.

IDLE:
- If read_kernel=1: clear kernel_valid and go to KREAD.
- Else if start=1: clear done and images_loaded and go to WAIT_BUF.
- read_kernel has priority when both are high.
- start or read_kernel while busy is ignored.

KREAD:
- Issues addresses KERNEL_BASE_ADDR + 4*i for i = 0..KERNEL_SIZE-1, one per cycle, pipelined.
- Captures data[KERNEL_WIDTH-1:0] into slot i READ_LATENCY cycles after address i is issued.
- kernel_valid rises the cycle after the last capture (KERNEL_SIZE+READ_LATENCY cycles after leaving IDLE), then returns to IDLE.

Batch addressing and buffering:
- Image n is read starting at IMAGE_BASE_ADDR + n*NUM_PIXELS*PIXEL_WIDTH/8 and targets buffer b = n mod 2.
- WAIT_BUF holds until buf_ready[b]=0.

FETCH:
- Drives the word address for one cycle.
- Waits READ_LATENCY cycles.
- Latches the word and enters UNPACK.

UNPACK:
- Writes PPW pixels on consecutive cycles, least-significant pixel first.
- aug_bram_addr = base_b + pixel index; all aug_bram_w_enable bits high.
- After a word's last pixel: go to FETCH if more words remain, else FINISH.
- Cost per word is 1+READ_LATENCY+PPW cycles: 6 cycles per word and 1176 cycles per image at the defaults.

FINISH:
- Sets buf_ready[b] and increments images_loaded, both visible in the cycle after the final write.
- If images_loaded reaches NUM_IMAGES: done=1 and go to IDLE.
- Otherwise go to WAIT_BUF for image n+1.

buf_release:
- buf_release[b] clears buf_ready[b] on the next edge.
- A release on a bit that is already 0 is ignored.
- Release and set of the same bit in one cycle cannot occur because WAIT_BUF guarantees the bit is 0 before filling; release wins if it does occur.

Other boundary conditions:
- done, kernel_out and buf_ready persist until the next start, read_kernel or reset respectively. buf_ready is also cleared by start.
- Reset mid-batch aborts immediately. The next start reloads from image 0.

Optional Feature:
- Macro: AUG_LOADER_STALL_CNT_EN.
- Defined: stall_cycles counts cycles spent in WAIT_BUF since the last start, saturating at 32'hFFFF_FFFF and cleared on start.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesised.

Test Plan:
- Kernel load: buffer words 0..8 = 32'hFFFF_F000+i, read_kernel pulse -> kernel_valid after 10 cycles; weight i = 12'h000+i; kernel_valid low during KREAD.
- Unpack: image 0 word 0 = 32'h4433_2211, consumer releases immediately -> aug writes 0x11,0x22,0x33,0x44 at 11'h000..11'h003; both w_enable bits high; buf_ready[0] rises after 1176 cycles.
- Ping-pong: NUM_IMAGES=4, consumer releases 10 cycles after each ready -> image 1 written at 11'h310..11'h61F, images 2/3 in buffers 0/1; done=1, images_loaded=4.
- Backpressure: never release buffer 0 -> loader stops in WAIT_BUF after image 1, busy=1; a release pulse resumes with image 2 into 11'h000; with macro, stall_cycles equals cycles held.
- Collisions: start and read_kernel high together in IDLE -> kernel load only; start while busy -> ignored; buf_release on a 0 bit -> no change.
- Reset mid-image (pixel 300) -> all outputs 0 asynchronously; a new start re-reads image 0 from IMAGE_BASE_ADDR 32'h24.
